period_meter: RTL

- Receive-side counterpart of the clock divider: takes a slow periodic signal and measures its period and high time in I_CLK cycles.
- Used to check divider outputs and to time external slow inputs, such as sensor or beacon pulses.
- Results go to the game logic through a valid/ready handshake.
- A timeout flag reports when the signal has stopped toggling.

---
 rtl/period_meter_if.sv | 31 +++
 rtl/period_meter.sv | 121 ++++++++++++
 2 files changed

// File: rtl/period_meter_if.sv
// Measurement result channel of period_meter.
//   meas_period : last measured period in I_CLK cycles (producer -> consumer)
//   meas_high   : last measured high time in I_CLK cycles (producer -> consumer)
//   meas_valid  : a measurement is pending (producer -> consumer)
//   meas_ready  : consumer accepts the pending measurement (consumer -> producer)
//   overrun     : one-cycle pulse, unacknowledged measurement overwritten (producer -> consumer)
interface period_meter_if #(
  parameter int unsigned W = 32
);
  logic [W-1:0] meas_period;
  logic [W-1:0] meas_high;
  logic         meas_valid;
  logic         meas_ready;
  logic         overrun;

  modport master (
    output meas_period,
    output meas_high,
    output meas_valid,
    output overrun,
    input  meas_ready
  );

  modport slave (
    input  meas_period,
    input  meas_high,
    input  meas_valid,
    input  overrun,
    output meas_ready
  );
endinterface

// File: rtl/period_meter.sv
// Measures period and high time of a slow, asynchronous periodic input in I_CLK cycles
// and hands each result to the consumer over a valid/ready channel.
//   I_CLK   : system clock, rising edge
//   rst     : asynchronous active-low reset
//   sig_in  : measured signal, asynchronous to I_CLK
//   meas    : result channel (period, high time, valid/ready, overrun pulse)
//   timeout : level flag, no rising edge seen for TIMEOUT cycles
module period_meter #(
  parameter int unsigned W           = 32,
  parameter int unsigned TIMEOUT     = 200000000,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic         I_CLK,
  input  logic         rst,
  input  logic         sig_in,
  period_meter_if.master meas,
  output logic         timeout
);

  typedef enum logic {StIdle, StMeasure} state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_d_q;
  logic [W-1:0]           cnt_q, cnt_d;
  logic [W-1:0]           hcnt_q, hcnt_d;
  logic [W-1:0]           period_q, period_d;
  logic [W-1:0]           high_q, high_d;
  logic                   valid_q, valid_d;
  logic                   overrun_q, overrun_d;
  logic                   timeout_q, timeout_d;
  logic                   s;
  logic                   rise;
  logic                   load;

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~s_d_q;

  always_ff @(posedge I_CLK or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      sync_q    <= '0;
      s_d_q     <= 1'b0;
      cnt_q     <= '0;
      hcnt_q    <= '0;
      period_q  <= '0;
      high_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync_q    <= {sync_q[SYNC_STAGES-2:0], sig_in};
      s_d_q     <= s;
      cnt_q     <= cnt_d;
      hcnt_q    <= hcnt_d;
      period_q  <= period_d;
      high_q    <= high_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hcnt_d    = hcnt_q;
    period_d  = period_q;
    high_d    = high_q;
    valid_d   = valid_q;
    overrun_d = 1'b0;
    timeout_d = timeout_q;
    load      = 1'b0;

    unique case (state_q)
      StIdle: begin
        // First edge only establishes the reference point.
        if (rise) begin
          cnt_d     = W'(1);
          hcnt_d    = W'(1);
          timeout_d = 1'b0;
          state_d   = StMeasure;
        end
      end
      StMeasure: begin
        if (rise) begin
          period_d = cnt_q;
          high_d   = hcnt_q;
          cnt_d    = W'(1);
          hcnt_d   = W'(1);
          load     = 1'b1;
        end else if (cnt_q == W'(TIMEOUT)) begin
          // Results of the last good period stay visible while stalled.
          timeout_d = 1'b1;
          state_d   = StIdle;
        end else begin
          cnt_d = cnt_q + W'(1);
          if (s) begin
            hcnt_d = hcnt_q + W'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (load) begin
      valid_d   = 1'b1;
      overrun_d = valid_q & ~meas.meas_ready;
    end else if (valid_q && meas.meas_ready) begin
      valid_d = 1'b0;
    end
  end

  assign meas.meas_period = period_q;
  assign meas.meas_high   = high_q;
  assign meas.meas_valid  = valid_q;
  assign meas.overrun     = overrun_q;
  assign timeout          = timeout_q;

endmodule
